// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Shared constants and types for the alu_seq execute sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   // ISA-level opcodes
   localparam logic [3:0] OPC_ADD  = 4'd0;
   localparam logic [3:0] OPC_SUB  = 4'd1;
   localparam logic [3:0] OPC_NAND = 4'd2;
   localparam logic [3:0] OPC_XOR  = 4'd3;
   localparam logic [3:0] OPC_SRA  = 4'd4;
   localparam logic [3:0] OPC_SRL  = 4'd5;
   localparam logic [3:0] OPC_SLL  = 4'd6;
   localparam logic [3:0] OPC_AND  = 4'd7;
   localparam logic [3:0] OPC_OR   = 4'd8;
   localparam logic [3:0] OPC_SEQ  = 4'd9;
   localparam logic [3:0] OPC_SLT  = 4'd10;
   localparam logic [3:0] OPC_SLE  = 4'd11;
   localparam logic [3:0] OPC_NEG  = 4'd12;

   // Native ALU operations
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_NAND = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_INC  = 3'b100;
   localparam logic [2:0] ALU_SRA  = 3'b101;
   localparam logic [2:0] ALU_SRL  = 3'b110;
   localparam logic [2:0] ALU_SLL  = 3'b111;

   // Sequencer states
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_P1   = 3'd1;
   localparam logic [2:0] S_P2   = 3'd2;
   localparam logic [2:0] S_P3   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // SEL_BSH is operand B masked to a 4-bit shift amount
   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_A    = 3'd1,
      SEL_B    = 3'd2,
      SEL_T0   = 3'd3,
      SEL_T1   = 3'd4,
      SEL_ONES = 3'd5,
      SEL_BSH  = 3'd6
   } sel_e;

   typedef enum logic [1:0] {
      TD_NONE = 2'd0,
      TD_T0   = 2'd1,
      TD_T1   = 2'd2
   } tdst_e;

   typedef enum logic [1:0] {
      POST_NONE = 2'd0,
      POST_EQ   = 2'd1,
      POST_LT   = 2'd2,
      POST_LE   = 2'd3
   } post_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_decode.sv
// ============================================================================
// Module  : alu_seq_decode
// Brief   : Per-pass micro-op decode. Compare opcodes need ALU_SEQ_CMP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [3:0] opcode_i,
   input  logic [1:0] pass_i,
   output logic [1:0] npass_o,
   output logic [2:0] alu_op_o,
   output sel_e       sel_a_o,
   output sel_e       sel_b_o,
   output tdst_e      tdst_o,
   output post_e      post_o,
   output logic       illegal_o
);

   always_comb begin
      npass_o   = 2'd1;
      alu_op_o  = ALU_ADD;
      sel_a_o   = SEL_A;
      sel_b_o   = SEL_B;
      tdst_o    = TD_NONE;
      post_o    = POST_NONE;
      illegal_o = 1'b0;
      case (opcode_i)
         OPC_ADD:  alu_op_o = ALU_ADD;
         OPC_SUB:  alu_op_o = ALU_SUB;
         OPC_NAND: alu_op_o = ALU_NAND;
         OPC_XOR:  alu_op_o = ALU_XOR;
         OPC_SRA: begin alu_op_o = ALU_SRA; sel_b_o = SEL_BSH; end
         OPC_SRL: begin alu_op_o = ALU_SRL; sel_b_o = SEL_BSH; end
         OPC_SLL: begin alu_op_o = ALU_SLL; sel_b_o = SEL_BSH; end
         OPC_AND: begin
            // a & b = ~NAND(a,b), with the inversion done as NAND(x, ones)
            npass_o  = 2'd2;
            alu_op_o = ALU_NAND;
            if (pass_i == 2'd0) begin
               tdst_o = TD_T0;
            end else begin
               sel_a_o = SEL_T0;
               sel_b_o = SEL_ONES;
            end
         end
         OPC_OR: begin
            // a | b = NAND(~a, ~b)
            npass_o  = 2'd3;
            alu_op_o = ALU_NAND;
            case (pass_i)
               2'd0: begin sel_a_o = SEL_A;  sel_b_o = SEL_A;  tdst_o = TD_T0; end
               2'd1: begin sel_a_o = SEL_B;  sel_b_o = SEL_B;  tdst_o = TD_T1; end
               default: begin sel_a_o = SEL_T0; sel_b_o = SEL_T1; end
            endcase
         end
`ifdef ALU_SEQ_CMP_EN
         OPC_SEQ: begin alu_op_o = ALU_SUB; post_o = POST_EQ; end
         OPC_SLT: begin alu_op_o = ALU_SUB; post_o = POST_LT; end
         OPC_SLE: begin alu_op_o = ALU_SUB; post_o = POST_LE; end
`endif
         OPC_NEG: begin alu_op_o = ALU_SUB; sel_a_o = SEL_ZERO; sel_b_o = SEL_A; end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : Multi-pass execute sequencer driving a 16-bit combinational ALU.
//           Define ALU_SEQ_CMP_EN to enable SEQ/SLT/SLE.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int ALU_SEQ_W = 16
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           req_opcode,
   input  logic [ALU_SEQ_W-1:0] req_a,
   input  logic [ALU_SEQ_W-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ALU_SEQ_W-1:0] rsp_data,
   output logic                 rsp_err,
   output logic                 flag_z,
   output logic                 flag_v,
   output logic                 flag_n,
   output logic [2:0]           alu_op,
   output logic [ALU_SEQ_W-1:0] alu_a,
   output logic [ALU_SEQ_W-1:0] alu_b,
   input  logic [ALU_SEQ_W-1:0] alu_result,
   input  logic                 alu_z,
   input  logic                 alu_v,
   input  logic                 alu_n
);

   logic [2:0]           state_q;
   logic [3:0]           op_q;
   logic [ALU_SEQ_W-1:0] a_q, b_q, t0_q, t1_q, rsp_data_q;
   logic                 rsp_err_q, z_q, v_q, n_q;

   logic [1:0]           w_pass, w_npass;
   logic                 w_in_pass, w_last, w_illegal;
   logic [2:0]           w_op;
   sel_e                 w_sel_a, w_sel_b;
   tdst_e                w_tdst;
   post_e                w_post;
   logic [ALU_SEQ_W-1:0] w_result;

   function automatic logic [ALU_SEQ_W-1:0] pick(
      input sel_e s, input logic [ALU_SEQ_W-1:0] a, b, t0, t1);
      case (s)
         SEL_A:    pick = a;
         SEL_B:    pick = b;
         SEL_T0:   pick = t0;
         SEL_T1:   pick = t1;
         SEL_ONES: pick = '1;
         SEL_BSH:  pick = {{(ALU_SEQ_W-4){1'b0}}, b[3:0]};
         default:  pick = '0;
      endcase
   endfunction

   always_comb begin
      w_pass    = 2'd0;
      w_in_pass = 1'b1;
      case (state_q)
         S_P1:    w_pass = 2'd0;
         S_P2:    w_pass = 2'd1;
         S_P3:    w_pass = 2'd2;
         default: w_in_pass = 1'b0;
      endcase
   end

   // In IDLE the decoder looks at the incoming opcode so illegal ops skip the passes
   alu_seq_decode u_decode (
      .opcode_i  ((state_q == S_IDLE) ? req_opcode : op_q),
      .pass_i    (w_pass),
      .npass_o   (w_npass),
      .alu_op_o  (w_op),
      .sel_a_o   (w_sel_a),
      .sel_b_o   (w_sel_b),
      .tdst_o    (w_tdst),
      .post_o    (w_post),
      .illegal_o (w_illegal)
   );

   assign w_last = ((w_pass + 2'd1) == w_npass);

   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (w_in_pass) begin
         alu_op = w_op;
         alu_a  = pick(w_sel_a, a_q, b_q, t0_q, t1_q);
         alu_b  = pick(w_sel_b, a_q, b_q, t0_q, t1_q);
      end
   end

`ifdef ALU_SEQ_CMP_EN
   always_comb begin
      case (w_post)
         POST_EQ: w_result = {{(ALU_SEQ_W-1){1'b0}}, alu_z};
         POST_LT: w_result = {{(ALU_SEQ_W-1){1'b0}}, alu_n ^ alu_v};
         POST_LE: w_result = {{(ALU_SEQ_W-1){1'b0}}, alu_z | (alu_n ^ alu_v)};
         default: w_result = alu_result;
      endcase
   end
`else
   logic w_unused_post;
   assign w_unused_post = ^w_post;
   assign w_result      = alu_result;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         t0_q       <= '0;
         t1_q       <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         z_q        <= 1'b0;
         v_q        <= 1'b0;
         n_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q <= req_opcode;
                  a_q  <= req_a;
                  b_q  <= req_b;
                  if (w_illegal) begin
                     state_q    <= S_DONE;
                     rsp_data_q <= '0;
                     rsp_err_q  <= 1'b1;
                  end else begin
                     state_q <= S_P1;
                  end
               end
            end
            S_P1, S_P2, S_P3: begin
               if (w_tdst == TD_T0) t0_q <= alu_result;
               if (w_tdst == TD_T1) t1_q <= alu_result;
               if (w_last) begin
                  state_q    <= S_DONE;
                  rsp_data_q <= w_result;
                  rsp_err_q  <= 1'b0;
                  z_q        <= alu_z;
                  v_q        <= alu_v;
                  n_q        <= alu_n;
               end else begin
                  state_q <= state_q + 3'd1;
               end
            end
            S_DONE: if (rsp_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign flag_z    = z_q;
   assign flag_v    = v_q;
   assign flag_n    = n_q;

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Execute-stage sequencer on the initiator side of the 16-bit ALU port. Accepts one decoded ISA-level operation per valid/ready handshake and drives the combinational ALU for one to three passes, feeding intermediates back as operands. Returns the registered result, an error bit, and a Z/V/N flag register. Composes AND, OR, NEG and set-on-compare instructions from the ALU's native op set.

## Interface
- `ALU_SEQ_W`, 16: datapath width; the only supported value.
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_opcode`  in  4  ISA-level op (see Operation).
- `req_a`, `req_b`  in  16 each  source operands.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  16  result.
- `rsp_err`  out  1  illegal opcode.
- `flag_z`, `flag_v`, `flag_n`  out  1 each  flag register.
- `alu_op`  out  3  to ALU: ADD 000, SUB 001, NAND 010, XOR 011, INC 100 (unused), SRA 101, SRL 110, SLL 111.
- `alu_a`, `alu_b`  out  16 each  ALU operands.
- `alu_result`  in  16  ALU result.
- `alu_z`, `alu_v`, `alu_n`  in  1 each  ALU flags. The ALU sets N only for ADD/SUB.

## Operation
- FSM states: IDLE, P1, P2, P3, DONE.
- On handshake in IDLE: latch opcode/a/b and go to P1. An illegal opcode goes straight to DONE.
- Each pass state drives `alu_*` from latched values and temporaries `t0`/`t1`. At the clock edge it captures `alu_result` and the ALU flags.
- Opcodes:
  - 0 ADD: ADD(a,b).
  - 1 SUB: SUB(a,b).
  - 2 NAND: NAND(a,b).
  - 3 XOR: XOR(a,b).
  - 4 SRA, 5 SRL, 6 SLL: one pass; `alu_b` = {12'b0, b[3:0]}.
  - 7 AND: P1 NAND(a,b)→t0; P2 NAND(t0,16'hFFFF).
  - 8 OR: P1 NAND(a,a)→t0; P2 NAND(b,b)→t1; P3 NAND(t0,t1).
  - 9 SEQ: SUB(a,b); result {15'b0,z}.
  - 10 SLT: SUB(a,b); result {15'b0, n^v}.
  - 11 SLE: SUB(a,b); result {15'b0, z|(n^v)}.
  - 12 NEG: SUB(16'h0,a).
  - 13–15: illegal.
- After the final pass, go to DONE. In DONE, `rsp_data`/`rsp_err` hold stable while `rsp_valid`=1 until `rsp_ready`, then return to IDLE.
- Flags load from the final pass of every legal op; compare ops use the SUB pass. An illegal op leaves flags unchanged. Flags also persist across IDLE.
- Widths: all arithmetic is 16-bit modulo. No carry out.
- In IDLE and DONE, drive `alu_op`=000 and `alu_a`=`alu_b`=0.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - flags 0, `t0`=`t1`=0.
  - `alu_*` outputs 0.
- Let the accept cycle be T and k the pass count (1, 2 or 3):
  - passes run in T+1..T+k;
  - `rsp_valid` rises at T+k+1;
  - an illegal op gives `rsp_valid` at T+1.
- `req_ready` is combinational from state (IDLE only). There is no overlap. The earliest next accept is the cycle after the response handshake.
- Under backpressure, `rsp_*` and flags stay frozen.
- Reset mid-op aborts: no response is produced and `req_ready`=1 in the cycle after reset.

## Configuration
- `ALU_SEQ_CMP_EN` defined: SEQ/SLT/SLE (9–11) are supported as above.
- `ALU_SEQ_CMP_EN` undefined: opcodes 9–11 are illegal and take the `rsp_err` path. The compare post-logic is removed.

## Structure
- Shared package/header `alu_seq_pkg`:
  - ISA opcode constants;
  - 3-bit ALU op constants;
  - FSM state encoding;
  - operand-select encoding (A, B, T0, T1, ZERO, ONES).
- Sub-module `alu_seq_decode` (combinational):
  - inputs: opcode and pass index;
  - outputs: pass count, ALU op, A/B select, temp destination, post-op select, illegal.

## Test plan
- ADD a=7FFF b=0001: `rsp_data`=8000, V=1, N=1, Z=0, `rsp_valid` at T+2.
- OR a=00F0 b=0F00: `alu_op`=010 in T+1..T+3, `rsp_data`=0FF0 at T+4. AND a=FF0F b=0FF0: result 0F00 at T+3.
- SLT a=8000 b=0001 → 0001 (N=0, V=1). SLE a=5 b=5 → 0001. SEQ a=5 b=6 → 0000. With the macro undefined, each of these → `rsp_err`=1.
- SLL a=0001 b=0013 → `alu_b`=0003, result 0008. NEG a=0001 → FFFF, N=1.
- Hold `rsp_ready` low 3 cycles after a SUB response: data, flags and `rsp_valid` stay stable, `req_ready`=0, and a new `req_valid` is ignored.
- Opcode D → `rsp_err`=1, `rsp_data`=0, flags unchanged, response at T+1. Assert `rst` in P2 of an OR → no response, and all outputs are at reset values the next cycle.
